// File: rtl/silencer_step.sv
// silencer_step: per-transducer slew limiter moving stored intensity/phase toward each burst's targets by a bounded step
module silencer_step #(
   parameter int DEPTH = 249
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        DIN_VALID,
   input  logic [15:0] INTENSITY_IN,
   input  logic [7:0]  PHASE_IN,
   input  logic [15:0] UPDATE_RATE_INT,
   input  logic [15:0] UPDATE_RATE_PHASE,
   output logic [15:0] INTENSITY_OUT,
   output logic [7:0]  PHASE_OUT,
   output logic        DOUT_VALID
);
   localparam int IW = $clog2(DEPTH);
   typedef enum logic {IDLE, RUN} state_t;
   state_t        state;
   logic [IW-1:0] idx, s1_idx;
   logic [15:0]   step_int, step_ph;
   logic [15:0]   cur_int [DEPTH];
   logic [15:0]   cur_ph  [DEPTH];
   logic          s1_valid;
   logic [15:0]   s1_c_int, s1_s_int, s1_c_ph, s1_t_ph, s1_d_ph, s1_s_ph;
   logic [16:0]   s1_d_int;
   logic [16:0]   mag_int, mag_ph;
   logic [15:0]   lim_int, new_int, new_ph;
   logic          last;
   assign last = idx == IW'(DEPTH - 1);
   // Phase distance is taken modulo 2^16, so -32768 has magnitude 32768 and steps downward.
   always_comb begin
      mag_int = s1_d_int[16] ? -s1_d_int : s1_d_int;
      lim_int = (mag_int > {1'b0, s1_s_int}) ? s1_s_int : mag_int[15:0];
      new_int = s1_d_int[16] ? s1_c_int - lim_int : s1_c_int + lim_int;
      mag_ph  = s1_d_ph[15] ? 17'h10000 - {1'b0, s1_d_ph} : {1'b0, s1_d_ph};
      new_ph  = (mag_ph <= {1'b0, s1_s_ph}) ? s1_t_ph :
                s1_d_ph[15] ? s1_c_ph - s1_s_ph : s1_c_ph + s1_s_ph;
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= IDLE;
         idx           <= '0;
         step_int      <= '0;
         step_ph       <= '0;
         s1_valid      <= 1'b0;
         s1_idx        <= '0;
         s1_c_int      <= '0;
         s1_d_int      <= '0;
         s1_s_int      <= '0;
         s1_c_ph       <= '0;
         s1_t_ph       <= '0;
         s1_d_ph       <= '0;
         s1_s_ph       <= '0;
         DOUT_VALID    <= 1'b0;
         INTENSITY_OUT <= '0;
         PHASE_OUT     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            cur_int[i] <= '0;
            cur_ph[i]  <= '0;
         end
      end else begin
         s1_valid   <= DIN_VALID;
         DOUT_VALID <= s1_valid;
         if (DIN_VALID) begin
            state    <= last ? IDLE : RUN;
            idx      <= last ? '0 : idx + 1'b1;
            s1_idx   <= idx;
            s1_c_int <= cur_int[idx];
            s1_d_int <= {1'b0, INTENSITY_IN} - {1'b0, cur_int[idx]};
            s1_c_ph  <= cur_ph[idx];
            s1_t_ph  <= {PHASE_IN, 8'h00};
            s1_d_ph  <= {PHASE_IN, 8'h00} - cur_ph[idx];
            s1_s_int <= (state == IDLE) ? UPDATE_RATE_INT : step_int;
            s1_s_ph  <= (state == IDLE) ? UPDATE_RATE_PHASE : step_ph;
            if (state == IDLE) begin
               step_int <= UPDATE_RATE_INT;
               step_ph  <= UPDATE_RATE_PHASE;
            end
         end
         if (s1_valid) begin
            cur_int[s1_idx] <= new_int;
            cur_ph[s1_idx]  <= new_ph;
            INTENSITY_OUT   <= new_int;
            PHASE_OUT       <= new_ph[15:8];
         end
      end
   end
endmodule

// File: tb/tb_silencer_step.sv
// tb_silencer_step: directed bursts checked every cycle against a per-transducer arithmetic model of the slew limiter
module tb_silencer_step;
   localparam int DEPTH = 249;
   logic        CLK = 0;
   logic        RST = 1;
   logic        DIN_VALID = 0;
   logic [15:0] INTENSITY_IN = 0;
   logic [7:0]  PHASE_IN = 0;
   logic [15:0] UPDATE_RATE_INT = 0;
   logic [15:0] UPDATE_RATE_PHASE = 0;
   logic [15:0] INTENSITY_OUT;
   logic [7:0]  PHASE_OUT;
   logic        DOUT_VALID;

   silencer_step #(.DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST), .DIN_VALID(DIN_VALID), .INTENSITY_IN(INTENSITY_IN), .PHASE_IN(PHASE_IN),
      .UPDATE_RATE_INT(UPDATE_RATE_INT), .UPDATE_RATE_PHASE(UPDATE_RATE_PHASE),
      .INTENSITY_OUT(INTENSITY_OUT), .PHASE_OUT(PHASE_OUT), .DOUT_VALID(DOUT_VALID)
   );

   always #5 CLK = ~CLK;

   typedef struct {int due; int i; int p;} exp_t;
   exp_t q[$];
   int   m_int[DEPTH];
   int   m_ph[DEPTH];
   int   m_idx = 0, ms_int = 0, ms_ph = 0;
   int   cyc = 0, checks = 0, failures = 0;
   int   l_int = 0, l_ph = 0;
   logic rst_seen = 0, armed = 0, ev;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   always @(posedge CLK) begin
      cyc      <= cyc + 1;
      rst_seen <= RST;
      armed    <= armed | RST;
   end

   // Outputs must match the model on every cycle: fresh values when a beat is due, held values otherwise.
   always @(negedge CLK) begin
      if (armed) begin
         ev = q.size() > 0 && q[0].due == cyc;
         if (rst_seen) begin
            l_int = 0;
            l_ph  = 0;
         end
         if (ev) begin
            l_int = q[0].i;
            l_ph  = q[0].p;
            void'(q.pop_front());
         end
         chk("dout_valid", {31'b0, DOUT_VALID}, {31'b0, ev});
         chk("intensity_out", {16'b0, INTENSITY_OUT}, l_int);
         chk("phase_out", {24'b0, PHASE_OUT}, l_ph);
      end
   end

   task automatic reset_cycle(input logic with_beat);
      @(posedge CLK); #1;
      RST = 1;
      DIN_VALID = with_beat;
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      foreach (m_int[k]) begin
         m_int[k] = 0;
         m_ph[k]  = 0;
      end
      m_idx = 0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge CLK); #1;
         RST = 0;
         DIN_VALID = 0;
      end
   endtask

   task automatic beat(input int ti, input int tp, input int ri, input int rp);
      int c, t, d, ad;
      @(posedge CLK); #1;
      RST = 0;
      DIN_VALID = 1;
      INTENSITY_IN = 16'(ti);
      PHASE_IN = 8'(tp);
      UPDATE_RATE_INT = 16'(ri);
      UPDATE_RATE_PHASE = 16'(rp);
      if (m_idx == 0) begin
         ms_int = ri;
         ms_ph  = rp;
      end
      c = m_int[m_idx];
      if (ti > c) c = c + ((ms_int < ti - c) ? ms_int : ti - c);
      else if (ti < c) c = c - ((ms_int < c - ti) ? ms_int : c - ti);
      m_int[m_idx] = c;
      t = tp * 256;
      c = m_ph[m_idx];
      d = (t - c + 65536) % 65536;
      if (d >= 32768) d = d - 65536;
      ad = (d < 0) ? -d : d;
      if (d != 0) begin
         if (ad <= ms_ph) c = t;
         else if (d > 0) c = (c + ms_ph) % 65536;
         else c = (c - ms_ph + 65536) % 65536;
      end
      m_ph[m_idx] = c;
      q.push_back('{due: cyc + 2, i: m_int[m_idx], p: m_ph[m_idx] / 256});
      m_idx = (m_idx + 1) % DEPTH;
   endtask

   task automatic burst(input int ti, input int tp, input int ri, input int rp);
      for (int k = 0; k < DEPTH; k++) beat(ti, tp, ri, rp);
      idle(4);
   endtask

   initial begin
      idle(0);
      reset_cycle(0);
      reset_cycle(0);
      idle(2);
      chk("reset_dout_valid", {31'b0, DOUT_VALID}, 0);
      chk("reset_intensity", {16'b0, INTENSITY_OUT}, 0);

      // Ramp: each burst moves every transducer up by 0x100 until 0x1000.
      for (int k = 1; k <= 20; k++) begin
         burst(16'h1000, 0, 16'h0100, 0);
         chk("ramp_intensity", {16'b0, INTENSITY_OUT}, (k * 256 < 4096) ? k * 256 : 4096);
      end
      chk("model_ramp_end", m_int[0], 32'h1000);

      // Phase wraps downward through zero.
      reset_cycle(0);
      burst(0, 8'hF0, 0, 16'h0800);
      chk("phase_wrap_1", {24'b0, PHASE_OUT}, 8'hF8);
      burst(0, 8'hF0, 0, 16'h0800);
      chk("phase_wrap_2", {24'b0, PHASE_OUT}, 8'hF0);
      burst(0, 8'hF0, 0, 16'h0800);
      chk("phase_wrap_hold", {24'b0, PHASE_OUT}, 8'hF0);
      chk("model_phase_wrap", m_ph[0], 32'hF000);

      // Half-circle distance steps downward.
      reset_cycle(0);
      burst(0, 8'h80, 0, 16'h1000);
      chk("phase_half_circle", {24'b0, PHASE_OUT}, 8'hF0);

      // Snap to target when within one step, freeze when step is zero.
      reset_cycle(0);
      burst(16'h0100, 0, 16'h0100, 0);
      burst(16'h0180, 0, 16'h0100, 0);
      chk("snap_up", {16'b0, INTENSITY_OUT}, 16'h0180);
      burst(0, 0, 16'h0100, 0);
      chk("step_down", {16'b0, INTENSITY_OUT}, 16'h0080);
      burst(16'hFFFF, 8'h40, 0, 0);
      chk("frozen_int", {16'b0, INTENSITY_OUT}, 16'h0080);
      chk("frozen_phase", {24'b0, PHASE_OUT}, 0);

      // Gapped input with per-transducer targets in both directions.
      for (int i = 0; i < DEPTH; i++) begin
         beat((i * 263) % 65536, i, 16'h0200, 16'h1000);
         if (i == 10) idle(3);
      end
      idle(2);
      for (int i = 0; i < DEPTH; i++) begin
         beat(65535 - i * 100, 255 - i, 16'h3000, 16'h9000);
         if (i == 10 || i == 200) idle(3);
      end
      idle(4);

      // Reset lands on beat 100 together with a valid beat.
      reset_cycle(0);
      for (int i = 0; i < 100; i++) beat(16'h1000, 0, 16'h0100, 0);
      reset_cycle(1);
      @(posedge CLK); #1;
      RST = 0;
      DIN_VALID = 0;
      chk("rst_mid_dout_valid", {31'b0, DOUT_VALID}, 0);
      burst(16'h1000, 0, 16'h0040, 0);
      chk("rst_restart_int", {16'b0, INTENSITY_OUT}, 16'h0040);
      chk("model_restart", m_int[DEPTH - 1], 32'h0040);
      idle(2);
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
